wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//   Shares the single register-file write port between the pipeline writeback stage (MEM/WB outputs) and an
//   auxiliary result source (GTE/COP2 moves, multiply/divide results) through a small in-order queue.
//   Sits between the MEM/WB pipeline register and the register file.
//   Drains queued results in idle WB slots; forces a one-cycle WB stall when a result has waited too long.
// PARAMETERS
//   DEPTH     2   aux queue entries (power of two, >=2)
//   MAX_WAIT  4   cycles the queue head may be blocked before a forced drain (>=1)
// PORTS
//   clock         in   1   clock, rising edge
//   reset         in   1   asynchronous, active-low reset
//   wb_regwrite   in   1   pipeline WB write enable
//   wb_rtrd       in   5   pipeline WB destination register
//   wb_data       in   32  pipeline WB write data (already muxed ReadData/ALU_Result)
//   aux_valid     in   1   aux result offered
//   aux_ready     out  1   queue can accept (registered, = !full)
//   aux_rd        in   5   aux destination register
//   aux_data      in   32  aux write data
//   rf_we         out  1   register-file write enable
//   rf_waddr      out  5   register-file write address
//   rf_wdata      out  32  register-file write data
//   wb_stall_req  out  1   request WB_Stall/M_Stall to hazard unit (registered)
//   aux_pending   out  32  per-register queued-write mask (only with WBARB_SCOREBOARD_EN)
// BEHAVIOUR
//   - Reset (async, reset==0): queue empty, wait counter 0, FSM=RUN, aux_ready=0 while reset held; 1 the first
//     cycle after release. wb_stall_req=0, rf_we=0, rf_waddr=0, rf_wdata=0, aux_pending=0.
//     Reset mid-operation discards all queued results.
//   - Accept: aux_valid & aux_ready at an edge enqueues {aux_rd, aux_data}.
//     Entries with aux_rd==0 are accepted, then dropped at dequeue without using the port.
//   - aux_ready derives from the registered count only. When full, no enqueue occurs, even while a dequeue happens.
//   - No bypass: minimum accept-to-write latency is 1 cycle; strict FIFO order within aux.
//   - pipe_wr = wb_regwrite & (wb_rtrd!=0).
//   - rf_* are combinational from the grant:
//       - pipeline grant: rf_we=1, addr/data = wb_*
//       - aux grant: rf_we=1, addr/data = queue head
//       - no grant: rf_we=0, addr/data = 0
//   - FSM RUN:
//       - pipe_wr=1: pipeline granted.
//           - Head valid and blocked -> wait counter +1.
//           - Counter reaching MAX_WAIT -> next state FORCE, wb_stall_req<=1.
//       - pipe_wr=0 and head valid: aux granted, head dequeued, counter cleared.
//       - Queue empty: counter held at 0.
//   - FSM FORCE (exactly 1 cycle, wb_stall_req=1):
//       - Aux head granted even if pipe_wr=1; the pipeline write is suppressed this cycle.
//       - The WB contents are held by the stall and written in the following cycle.
//       - Dequeue, counter cleared, next state RUN, wb_stall_req<=0.
//   - Wait counter width = $clog2(MAX_WAIT+1); it saturates and never wraps.
//   - Write ordering between pipeline and aux to the same register is not resolved here. The hazard unit
//     interlocks using aux_pending.
//   - Count range 0..DEPTH. Pointers wrap modulo DEPTH.
// CONFIGURATION
//   WBARB_SCOREBOARD_EN defined:
//     - aux_pending[r]=1 while any queued entry targets r (r!=0); bit 0 is always 0.
//     - Register updated on enqueue/dequeue edges; it reflects a dequeue in the cycle after the write.
//     - Per-register occupancy tracked as a count of up to DEPTH entries, so duplicates clear correctly.
//   Not defined: aux_pending tied to 32'b0, no tracking logic.
// TESTING
//   1. Reset held 3 cycles mid-traffic -> all outputs 0, queue empty; aux_ready=1 the first cycle after release.
//   2. Enqueue {rd=5,0xA5A5_0001} with wb_regwrite=0 -> next cycle rf_we=1, waddr=5, wdata=0xA5A5_0001.
//      aux_ready stays 1.
//   3. Fill 2 entries while wb_regwrite=1 (rd=7) continuously:
//      - aux_ready=0 when full.
//      - Head blocked 4 cycles -> wb_stall_req=1 for exactly 1 cycle, aux head written in that cycle.
//      - rd=7 written the next cycle.
//   4. Enqueue aux_rd=0 -> entry consumed with rf_we=0; next entry written in the following idle slot.
//   5. Full queue, simultaneous aux_valid and dequeue -> no enqueue that edge; aux_ready=1 after it, then accept.
//   6. (SCOREBOARD_EN) enqueue rd=9 twice -> aux_pending[9]=1 until the second write; cleared one cycle after.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback and a queued aux result source.
// Optional per-register pending-write scoreboard enabled by defining WBARB_SCOREBOARD_EN.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rtrd,
    input  logic [31:0] wb_data,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_rd,
    input  logic [31:0] aux_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_stall_req,
    output logic [31:0] aux_pending
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] MAXW = WW'(MAX_WAIT);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {RUN, FORCE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          stall_q, stall_d, ready_q, ready_d;
    logic [4:0]    rd_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic          pipe_wr, head_valid, enq, deq, aux_gnt, pipe_gnt;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    assign pipe_wr    = wb_regwrite && wb_rtrd != 5'd0;
    assign head_valid = count_q != '0;
    assign head_rd    = rd_mem[rd_ptr_q];
    assign head_data  = data_mem[rd_ptr_q];
    assign enq        = aux_valid && ready_q;
    assign deq        = aux_gnt;

    always_comb begin
        state_d  = RUN;
        wait_d   = '0;
        aux_gnt  = 1'b0;
        pipe_gnt = 1'b0;
        if (state_q == FORCE) begin
            aux_gnt = head_valid;
        end else if (pipe_wr) begin
            pipe_gnt = reset;
            if (head_valid) begin
                wait_d  = (wait_q == MAXW) ? wait_q : wait_q + 1'b1;
                state_d = (wait_d == MAXW) ? FORCE : RUN;
            end
        end else begin
            aux_gnt = head_valid;
        end
        stall_d  = state_d == FORCE;
        count_d  = count_q + CW'(enq) - CW'(deq);
        wr_ptr_d = wr_ptr_q + PW'(enq);
        rd_ptr_d = rd_ptr_q + PW'(deq);
        ready_d  = count_d != FULL;
    end

    // Aux entries targeting r0 take their grant slot but never drive the port.
    always_comb begin
        rf_we    = pipe_gnt || (aux_gnt && head_rd != 5'd0);
        rf_waddr = !rf_we ? 5'd0 : aux_gnt ? head_rd : wb_rtrd;
        rf_wdata = !rf_we ? 32'd0 : aux_gnt ? head_data : wb_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wait_q   <= '0;
            stall_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wait_q   <= wait_d;
            stall_q  <= stall_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            rd_mem[wr_ptr_q]   <= aux_rd;
            data_mem[wr_ptr_q] <= aux_data;
        end
    end

    assign aux_ready    = ready_q;
    assign wb_stall_req = stall_q;

`ifdef WBARB_SCOREBOARD_EN
    logic [CW-1:0] pend_q [32];
    logic [CW-1:0] pend_d [32];

    // Per-register occupancy counts so duplicate destinations clear only on their last dequeue.
    always_comb begin
        aux_pending = '0;
        for (int r = 0; r < 32; r++) begin
            pend_d[r] = pend_q[r] + CW'(enq && r != 0 && aux_rd == 5'(r))
                                  - CW'(deq && r != 0 && head_rd == 5'(r));
            aux_pending[r] = pend_q[r] != '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) pend_q[r] <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    assign aux_pending = 32'b0;
`endif
endmodule
